adxl362_scheduler: RTL and testbench
====================================

# adxl362_scheduler

Sequences and shares the ADXL362 SPI register-access controller between two requesters: a manual request port (driven by the board-level button/switch logic) and an internal periodic poll engine that reads X/Y/Z acceleration. After reset it configures the sensor into measurement mode. It sits between the top-level board glue and the existing single-transaction ADXL362 controller, replacing direct button-to-controller wiring.

## Interface
- CLK_FREQUENCY, 100_000_000, system clock frequency in Hz
- POLL_RATE_HZ, 100, poll burst rate; 0 disables the poll engine
- POLL_CYCLES, CLK_FREQUENCY/POLL_RATE_HZ, derived localparam, poll period in clocks

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  manual request present
- req_write  in  1  1 = write, 0 = read
- req_addr  in  8  register address
- req_wdata  in  8  write data
- req_ready  out  1  manual request accepted when req_valid && req_ready
- rsp_valid  out  1  one-cycle pulse at manual transaction completion
- rsp_rdata  out  8  read data of last manual transaction; held until next
- x_data, y_data, z_data  out  8 each  latest polled sample
- sample_valid  out  1  one-cycle pulse when all three sample registers update
- poll_overrun  out  1  sticky; poll period expired while a poll was still pending
- ctl_start  out  1  one-cycle start pulse to the SPI controller
- ctl_write  out  1  transaction type, valid with ctl_start
- ctl_addr, ctl_wdata  out  8 each  held stable from ctl_start until ctl_done
- ctl_busy  in  1  controller busy
- ctl_done  in  1  one-cycle pulse at transaction end
- ctl_rdata  in  8  read data, valid with ctl_done

## Operation
- States: INIT_ISSUE, INIT_WAIT, IDLE, MAN_ISSUE, MAN_WAIT, POLL_ISSUE, POLL_WAIT.
- INIT: write 0x02 to POWER_CTL (0x2D). INIT_ISSUE asserts ctl_start when ctl_busy=0; INIT_WAIT waits for ctl_done, then IDLE.
- Poll timer: counts 0..POLL_CYCLES-1, free-running from reset; at terminal count sets poll_pending. Terminal count with poll_pending already set sets poll_overrun (cleared only by rst).
- IDLE arbitration, one grant per transaction boundary:
  - only manual valid -> MAN_ISSUE; only poll_pending -> POLL_ISSUE.
  - both: grant the requester not granted last (last_grant flag, reset to poll so manual wins the first tie).
- req_ready = IDLE && !(poll_pending && last_grant==manual); request captured on handshake into MAN_ISSUE.
- Manual: one transaction; at ctl_done, rsp_rdata <= ctl_rdata (reads only; unchanged on writes), rsp_valid pulses, return to IDLE.
- Poll burst is atomic (never interleaved with manual): reads 0x08, 0x09, 0x0A in order via index 0..2; each ctl_done stores into a shadow byte; after the third, x/y/z_data update together, sample_valid pulses, poll_pending clears, return to IDLE.
- ctl_done arriving in any state other than *_WAIT is ignored.

## Timing
- Reset values: all outputs 0; state INIT_ISSUE; timer 0; poll_pending 0; last_grant poll.
- ctl_start asserted in the cycle after entering *_ISSUE if ctl_busy=0; stays in *_ISSUE while ctl_busy=1.
- rsp_valid / sample_valid assert the cycle after the final ctl_done.
- IDLE to ctl_start: 2 cycles after handshake or pending.
- rst mid-transaction: immediate return to reset values; the SPI controller shares rst, so no transaction is resumed; INIT repeats.
- POLL_RATE_HZ=0: timer held at 0, poll_pending never set.

## Configuration
- ADXL362_SCHED_STATUS_EN defined: each poll burst first reads STATUS (0x0B); if bit0 (DATA_READY)=0 the burst ends, poll_pending clears, and no sample_valid is pulsed; otherwise X/Y/Z are read as above (4 transactions).
- Undefined: burst is X/Y/Z only, always updating samples.

## Structure
- adxl362_pkg: register address constants (DEVID_AD 0x00, PARTID 0x02, XDATA 0x08, YDATA 0x09, ZDATA 0x0A, STATUS 0x0B, SOFT_RESET 0x1F, POWER_CTL 0x2D), POWER_CTL_MEASURE 0x02, state enum typedef.
- Sub-module adxl362_poll_timer: counter, terminal pulse, enable from POLL_RATE_HZ.

## Test plan
- Reset -> first ctl_start writes addr 0x2D, data 0x02; req_ready stays 0 until INIT done.
- Manual read 0x00 with adxl362 model -> rsp_valid once, rsp_rdata 0xAD; read 0x02 -> 0xF2.
- POLL_RATE_HZ=1_000_000 (100-cycle period) -> reads 0x08,0x09,0x0A in order, x/y/z match model, one sample_valid per period.
- Manual req_valid held during poll tick -> burst not interrupted; ties alternate manual, poll, manual.
- Stall controller (ctl_busy=1) past two periods -> poll_overrun=1, stays 1 until rst.
- Assert rst during MAN_WAIT -> outputs 0 next cycle, INIT write 0x2D reissued, no stale rsp_valid.

Source files
------------

// File: rtl/adxl362_pkg.sv
// ADXL362 register map, scheduler state encoding and poll address sequencing.
// Define ADXL362_SCHED_STATUS_EN to prefix each poll burst with a STATUS read.
package adxl362_pkg;

   localparam logic [7:0] REG_DEVID_AD   = 8'h00;
   localparam logic [7:0] REG_PARTID     = 8'h02;
   localparam logic [7:0] REG_XDATA      = 8'h08;
   localparam logic [7:0] REG_YDATA      = 8'h09;
   localparam logic [7:0] REG_ZDATA      = 8'h0A;
   localparam logic [7:0] REG_STATUS     = 8'h0B;
   localparam logic [7:0] REG_SOFT_RESET = 8'h1F;
   localparam logic [7:0] REG_POWER_CTL  = 8'h2D;

   localparam logic [7:0] POWER_CTL_MEASURE = 8'h02;

   typedef enum logic [2:0] {
      INIT_ISSUE = 3'd0,
      INIT_WAIT  = 3'd1,
      IDLE       = 3'd2,
      MAN_ISSUE  = 3'd3,
      MAN_WAIT   = 3'd4,
      POLL_ISSUE = 3'd5,
      POLL_WAIT  = 3'd6
   } sched_state_e;

   typedef enum logic {
      GRANT_POLL = 1'b0,
      GRANT_MAN  = 1'b1
   } grant_e;

   // Register read by step idx of a poll burst.
   function automatic logic [7:0] poll_addr(input logic [1:0] idx);
`ifdef ADXL362_SCHED_STATUS_EN
      return (idx == 2'd0) ? REG_STATUS : (REG_XDATA + {6'd0, idx} - 8'd1);
`else
      return REG_XDATA + {6'd0, idx};
`endif
   endfunction

endpackage

// File: rtl/adxl362_poll_timer.sv
// Free-running poll period counter; tick marks the terminal count.
// Held at zero with tick low when ENABLE is clear.
module adxl362_poll_timer #(
   parameter int unsigned CYCLES = 1,
   parameter bit          ENABLE = 1'b1
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(CYCLES - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (ENABLE) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/adxl362_scheduler.sv
// Shares the ADXL362 SPI controller between a manual port and a periodic X/Y/Z poll.
// Define ADXL362_SCHED_STATUS_EN to gate each poll burst on STATUS.DATA_READY.
module adxl362_scheduler
   import adxl362_pkg::*;
#(
   parameter int unsigned CLK_FREQUENCY = 100_000_000,
   parameter int unsigned POLL_RATE_HZ  = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic       req_write,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       req_ready,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic [7:0] x_data,
   output logic [7:0] y_data,
   output logic [7:0] z_data,
   output logic       sample_valid,
   output logic       poll_overrun,
   output logic       ctl_start,
   output logic       ctl_write,
   output logic [7:0] ctl_addr,
   output logic [7:0] ctl_wdata,
   input  logic       ctl_busy,
   input  logic       ctl_done,
   input  logic [7:0] ctl_rdata
);

   localparam int unsigned POLL_DIV =
      CLK_FREQUENCY / ((POLL_RATE_HZ == 0) ? 1 : POLL_RATE_HZ);
   localparam int unsigned POLL_CYCLES = (POLL_DIV == 0) ? 1 : POLL_DIV;
   localparam bit          POLL_EN     = (POLL_RATE_HZ != 0);

   sched_state_e state_q, state_d;
   grant_e       last_grant_q, last_grant_d;
   logic         pending_q, pending_d;
   logic         overrun_q, overrun_d;
   logic [1:0]   idx_q, idx_d;
   logic         man_write_q, man_write_d;
   logic [7:0]   man_addr_q, man_addr_d;
   logic [7:0]   man_wdata_q, man_wdata_d;
   logic         start_q, start_d;
   logic         write_q, write_d;
   logic [7:0]   addr_q, addr_d;
   logic [7:0]   wdata_q, wdata_d;
   logic         rsp_valid_q, rsp_valid_d;
   logic [7:0]   rsp_rdata_q, rsp_rdata_d;
   logic [7:0]   x_q, x_d;
   logic [7:0]   y_q, y_d;
   logic [7:0]   z_q, z_d;
   logic [7:0]   shx_q, shx_d;
   logic [7:0]   shy_q, shy_d;
   logic         sample_q, sample_d;
   logic         tick;
   logic         poll_clear;
   logic [7:0]   paddr;

   adxl362_poll_timer #(
      .CYCLES (POLL_CYCLES),
      .ENABLE (POLL_EN)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Manual is held off only when it won the previous tie and a poll waits.
   assign req_ready = (state_q == IDLE) &&
                      !(pending_q && (last_grant_q == GRANT_MAN));

   assign paddr = poll_addr(idx_q);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      idx_d        = idx_q;
      man_write_d  = man_write_q;
      man_addr_d   = man_addr_q;
      man_wdata_d  = man_wdata_q;
      start_d      = 1'b0;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rsp_valid_d  = 1'b0;
      rsp_rdata_d  = rsp_rdata_q;
      x_d          = x_q;
      y_d          = y_q;
      z_d          = z_q;
      shx_d        = shx_q;
      shy_d        = shy_q;
      sample_d     = 1'b0;
      poll_clear   = 1'b0;

      unique case (state_q)
         INIT_ISSUE: begin
            if (!ctl_busy) begin
               start_d = 1'b1;
               write_d = 1'b1;
               addr_d  = REG_POWER_CTL;
               wdata_d = POWER_CTL_MEASURE;
               state_d = INIT_WAIT;
            end
         end
         INIT_WAIT: begin
            if (ctl_done) state_d = IDLE;
         end
         IDLE: begin
            if (req_valid && req_ready) begin
               man_write_d  = req_write;
               man_addr_d   = req_addr;
               man_wdata_d  = req_wdata;
               last_grant_d = GRANT_MAN;
               state_d      = MAN_ISSUE;
            end else if (pending_q) begin
               last_grant_d = GRANT_POLL;
               idx_d        = 2'd0;
               state_d      = POLL_ISSUE;
            end
         end
         MAN_ISSUE: begin
            if (!ctl_busy) begin
               start_d = 1'b1;
               write_d = man_write_q;
               addr_d  = man_addr_q;
               wdata_d = man_wdata_q;
               state_d = MAN_WAIT;
            end
         end
         MAN_WAIT: begin
            if (ctl_done) begin
               if (!man_write_q) rsp_rdata_d = ctl_rdata;
               rsp_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         POLL_ISSUE: begin
            if (!ctl_busy) begin
               start_d = 1'b1;
               write_d = 1'b0;
               addr_d  = paddr;
               wdata_d = 8'h00;
               state_d = POLL_WAIT;
            end
         end
         POLL_WAIT: begin
            if (ctl_done) begin
               idx_d   = idx_q + 2'd1;
               state_d = POLL_ISSUE;
               unique case (paddr)
                  REG_STATUS: begin
                     if (!ctl_rdata[0]) begin
                        poll_clear = 1'b1;
                        state_d    = IDLE;
                     end
                  end
                  REG_XDATA: shx_d = ctl_rdata;
                  REG_YDATA: shy_d = ctl_rdata;
                  REG_ZDATA: begin
                     x_d        = shx_q;
                     y_d        = shy_q;
                     z_d        = ctl_rdata;
                     sample_d   = 1'b1;
                     poll_clear = 1'b1;
                     state_d    = IDLE;
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
         default: state_d = INIT_ISSUE;
      endcase
   end

   // A new period re-arms the poll even if a burst finishes this cycle.
   always_comb begin
      pending_d = pending_q;
      if (poll_clear) pending_d = 1'b0;
      if (tick)       pending_d = 1'b1;
      overrun_d = overrun_q | (tick & pending_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= INIT_ISSUE;
         last_grant_q <= GRANT_POLL;
         pending_q    <= 1'b0;
         overrun_q    <= 1'b0;
         idx_q        <= 2'd0;
         man_write_q  <= 1'b0;
         man_addr_q   <= 8'h00;
         man_wdata_q  <= 8'h00;
         start_q      <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= 8'h00;
         wdata_q      <= 8'h00;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= 8'h00;
         x_q          <= 8'h00;
         y_q          <= 8'h00;
         z_q          <= 8'h00;
         shx_q        <= 8'h00;
         shy_q        <= 8'h00;
         sample_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         idx_q        <= idx_d;
         man_write_q  <= man_write_d;
         man_addr_q   <= man_addr_d;
         man_wdata_q  <= man_wdata_d;
         start_q      <= start_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         x_q          <= x_d;
         y_q          <= y_d;
         z_q          <= z_d;
         shx_q        <= shx_d;
         shy_q        <= shy_d;
         sample_q     <= sample_d;
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign x_data       = x_q;
   assign y_data       = y_q;
   assign z_data       = z_q;
   assign sample_valid = sample_q;
   assign poll_overrun = overrun_q;
   assign ctl_start    = start_q;
   assign ctl_write    = write_q;
   assign ctl_addr     = addr_q;
   assign ctl_wdata    = wdata_q;

endmodule

// File: tb/tb_adxl362_scheduler.sv
// Bench for adxl362_scheduler: sensor/controller model, directed phases, random data.
// Poll period is 100 clocks (1 MHz poll at 100 MHz clock).
module tb_adxl362_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic [7:0] req_addr = 8'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       req_ready;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic [7:0] x_data, y_data, z_data;
   logic       sample_valid;
   logic       poll_overrun;
   logic       ctl_start, ctl_write;
   logic [7:0] ctl_addr, ctl_wdata;
   logic       ctl_busy = 1'b0;
   logic       ctl_done = 1'b0;
   logic [7:0] ctl_rdata = 8'h00;

   always #5 clk = ~clk;

   adxl362_scheduler #(
      .CLK_FREQUENCY (100_000_000),
      .POLL_RATE_HZ  (1_000_000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .x_data       (x_data),
      .y_data       (y_data),
      .z_data       (z_data),
      .sample_valid (sample_valid),
      .poll_overrun (poll_overrun),
      .ctl_start    (ctl_start),
      .ctl_write    (ctl_write),
      .ctl_addr     (ctl_addr),
      .ctl_wdata    (ctl_wdata),
      .ctl_busy     (ctl_busy),
      .ctl_done     (ctl_done),
      .ctl_rdata    (ctl_rdata)
   );

   typedef struct packed {
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
   } txn_t;

   txn_t       log_q[$];
   logic [7:0] mem [256];
   int         checks = 0;
   int         errors = 0;
   int         rsp_cnt = 0;
   int         sv_cnt = 0;
   logic       stall = 1'b0;
   logic       act = 1'b0;
   int         lat = 0;
   txn_t       cur;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Sensor behind an SPI controller: fixed register file, random latency.
   always @(negedge clk) begin
      if (rst) begin
         act       = 1'b0;
         ctl_done  = 1'b0;
         ctl_rdata = 8'h00;
      end else begin
         ctl_done = 1'b0;
         if (act) begin
            lat--;
            if (lat == 0) begin
               act      = 1'b0;
               ctl_done = 1'b1;
               if (cur.w) begin
                  mem[cur.a] = cur.d;
                  ctl_rdata  = 8'h00;
               end else begin
                  ctl_rdata = mem[cur.a];
               end
            end
         end else if (ctl_start) begin
            act = 1'b1;
            lat = $urandom_range(2, 5);
            cur = '{w: ctl_write, a: ctl_addr, d: ctl_wdata};
            log_q.push_back(cur);
         end
      end
      ctl_busy = act || stall;
   end

   // Every published sample must equal what the sensor held; then move the sensor.
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid) rsp_cnt++;
         if (sample_valid) begin
            sv_cnt++;
            chk("x_data", x_data, mem[8'h08]);
            chk("y_data", y_data, mem[8'h09]);
            chk("z_data", z_data, mem[8'h0A]);
            mem[8'h08] = 8'($urandom);
            mem[8'h09] = 8'($urandom);
            mem[8'h0A] = 8'($urandom);
         end
      end
   end

   task automatic wait_log(input int n, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         if (log_q.size() >= n) ok = 1'b1;
         else cyc(1);
      end
      chk(tag, ok, 1);
   endtask

   task automatic man_txn(input logic w, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] exp,
                          input string tag);
      bit hs = 1'b0;
      bit got = 1'b0;
      int n0;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      for (int i = 0; i < 400 && !hs; i++) begin
         if (req_ready) hs = 1'b1;
         cyc(1);
      end
      req_valid = 1'b0;
      chk({tag, "_handshake"}, hs, 1);
      n0 = rsp_cnt;
      for (int i = 0; i < 400 && !got; i++) begin
         cyc(1);
         if (rsp_valid) got = 1'b1;
      end
      chk({tag, "_rsp_seen"}, got, 1);
      cyc(3);
      chk({tag, "_rsp_once"}, rsp_cnt - n0, 1);
      chk({tag, "_rdata"}, rsp_rdata, exp);
   endtask

   initial begin
      logic [7:0] last_rd;
      logic [7:0] a, d;
      int         n0, bursts, hs;
      bit         ok;

      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h00] = 8'hAD;
      mem[8'h02] = 8'hF2;
      mem[8'h0B] = 8'h01;

      // Reset state and the INIT write.
      cyc(3);
      chk("rst_ctl_start", ctl_start, 0);
      chk("rst_ctl_addr", ctl_addr, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_x_data", x_data, 0);
      chk("rst_sample_valid", sample_valid, 0);
      chk("rst_overrun", poll_overrun, 0);
      rst = 1'b0;
      wait_log(1, "init_start_seen");
      chk("init_req_ready", req_ready, 0);
      chk("init_write", log_q[0].w, 1);
      chk("init_addr", log_q[0].a, 8'h2D);
      chk("init_wdata", log_q[0].d, 8'h02);

      // Manual reads and random write/read-back.
      man_txn(1'b0, 8'h00, 8'h00, 8'hAD, "rd_devid");
      man_txn(1'b0, 8'h02, 8'h00, 8'hF2, "rd_partid");
      last_rd = 8'hF2;
      for (int k = 0; k < 3; k++) begin
         a = 8'h20 + 8'($urandom_range(0, 7));
         d = 8'($urandom);
         man_txn(1'b1, a, d, last_rd, "wr_keep_rdata");
         man_txn(1'b0, a, 8'h00, d, "rd_back");
         last_rd = d;
      end

      // One sample per 100-clock period.
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         cyc(1);
         if (sample_valid) ok = 1'b1;
      end
      chk("sample_seen", ok, 1);
      cyc(1);
      n0 = sv_cnt;
      cyc(949);
      chk("sample_rate", sv_cnt - n0, 9);
      chk("no_overrun", poll_overrun, 0);

      // Bursts read X, Y, Z back to back.
      bursts = 0;
      for (int i = 0; i + 2 < log_q.size(); i++) begin
         if (!log_q[i].w && log_q[i].a == 8'h08) begin
            bursts++;
            chk("order_y", {log_q[i+1].w, log_q[i+1].a}, 9'h009);
            chk("order_z", {log_q[i+2].w, log_q[i+2].a}, 9'h00A);
         end
      end
      chk("bursts_found", bursts >= 9, 1);

      // Stalled controller across two periods.
      stall = 1'b1;
      cyc(250);
      chk("overrun_set", poll_overrun, 1);
      stall = 1'b0;
      cyc(150);
      chk("overrun_sticky", poll_overrun, 1);

      // Reset with controller stalled, both requesters waiting at INIT end.
      stall     = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 8'h00;
      rst       = 1'b1;
      log_q.delete();
      cyc(3);
      chk("overrun_cleared", poll_overrun, 0);
      chk("rst2_rsp_rdata", rsp_rdata, 0);
      rst = 1'b0;
      cyc(105);
      chk("stall_no_start", log_q.size(), 0);
      chk("stall_req_ready", req_ready, 0);
      stall = 1'b0;
      hs = 0;
      for (int i = 0; i < 400 && hs < 2; i++) begin
         if (req_ready) begin
            cyc(1);
            hs++;
            req_addr = 8'h02;
         end else begin
            cyc(1);
         end
      end
      req_valid = 1'b0;
      chk("tie_handshakes", hs, 2);
      wait_log(6, "tie_log");
      cyc(20);
      chk("tie_init", log_q[0].a, 8'h2D);
      chk("tie_first_man", {log_q[1].w, log_q[1].a}, 9'h000);
      chk("tie_poll_x", {log_q[2].w, log_q[2].a}, 9'h008);
      chk("tie_poll_y", {log_q[3].w, log_q[3].a}, 9'h009);
      chk("tie_poll_z", {log_q[4].w, log_q[4].a}, 9'h00A);
      chk("tie_second_man", {log_q[5].w, log_q[5].a}, 9'h002);
      chk("tie_rdata", rsp_rdata, 8'hF2);

      // Reset while a manual read is outstanding.
      n0 = log_q.size();
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 8'h00;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         cyc(1);
         if (log_q.size() > n0 && !log_q[$].w && log_q[$].a == 8'h00)
            ok = 1'b1;
         n0 = ok ? n0 : log_q.size();
      end
      chk("man_wait_reached", ok, 1);
      rst       = 1'b1;
      req_valid = 1'b0;
      log_q.delete();
      n0 = rsp_cnt;
      cyc(1);
      chk("rst3_ctl_start", ctl_start, 0);
      chk("rst3_ctl_addr", ctl_addr, 0);
      chk("rst3_rsp_valid", rsp_valid, 0);
      chk("rst3_rsp_rdata", rsp_rdata, 0);
      chk("rst3_x_data", x_data, 0);
      chk("rst3_req_ready", req_ready, 0);
      cyc(2);
      rst = 1'b0;
      wait_log(1, "reinit_seen");
      chk("reinit_write", log_q[0].w, 1);
      chk("reinit_addr", log_q[0].a, 8'h2D);
      chk("reinit_wdata", log_q[0].d, 8'h02);
      cyc(30);
      chk("no_stale_rsp", rsp_cnt - n0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
